mult_share_sched: RTL
=====================

Name: mult_share_sched

Overview:
- Time-shares one combinational 8x8 array multiplier (Wallace/lookahead type, instantiated outside this block) among NREQ requesters.
- Arbitrates valid/ready requests round-robin, registers the winning operands onto the multiplier inputs, and waits a fixed settle time.
- Captures the product and returns it with the requester ID over a valid/ready response port.
- Sits between the multiplier datapath and its client blocks.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width; product is 2*WIDTH.
- MUL_LAT, 2, clock cycles allowed for the combinational multiplier to settle (>=1).
- IDW, 2, width of requester ID; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept; at most one bit high.
- req_a  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing as req_a.
- mul_a  out  WIDTH  registered operand A to the shared multiplier.
- mul_b  out  WIDTH  registered operand B to the shared multiplier.
- mul_p  in  2*WIDTH  product returned by the shared multiplier.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_prod  out  2*WIDTH  captured product.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, CALC, HOLD.
- Reset (async, any time, mid-operation included):
  - state=IDLE, rr_ptr=0, cnt=0.
  - mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_prod=0, busy=0.
  - Any in-flight operation is discarded with no response.
- IDLE:
  - req_ready is combinational. Search starts at rr_ptr and wraps modulo NREQ; the first i with req_valid[i]=1 gets req_ready[i]=1.
  - req_ready is all-zero outside IDLE and whenever no request is valid.
- Accept: req_valid[i]&req_ready[i] at a rising edge. On that edge:
  - mul_a<=req_a[i], mul_b<=req_b[i], rsp_id<=i.
  - cnt<=MUL_LAT-1, rr_ptr<=(i+1) mod NREQ, state<=CALC.
- CALC:
  - If cnt!=0, cnt decrements each cycle.
  - On the edge where cnt==0: rsp_prod<=mul_p, rsp_valid<=1, state<=HOLD.
  - Latency from the accept edge to rsp_valid high is exactly MUL_LAT cycles.
  - mul_a and mul_b are held stable throughout CALC.
- HOLD:
  - rsp_valid, rsp_id and rsp_prod stay stable until rsp_ready=1 at an edge.
  - On that edge: rsp_valid<=0, state<=IDLE.
  - mul_a and mul_b retain their last values (no toggle power).
- No overlap: a new request cannot be accepted in the same cycle as the response handshake. Earliest next accept is the cycle after the handshake.
- Best-case throughput: one product per MUL_LAT+2 cycles.
- Requester rules:
  - A requester must hold req_valid, req_a and req_b stable until accepted.
  - A requester may not wait for req_ready before asserting req_valid.
  - The block samples operands only on the accept edge.
- Fairness: a continuously requesting client waits at most NREQ-1 grants.
- Arithmetic: the product is unsigned, full 2*WIDTH bits, never truncated.
- rsp_ready held high while in HOLD: the response completes after exactly one HOLD cycle.
- Deasserting req_valid in IDLE before an accept is legal; no state change results.

Optional Feature:
- Macro MULT_SHARE_ZERO_BYPASS_EN.
- Defined:
  - On accept, if either operand is 0, go straight to HOLD: rsp_prod<=0, rsp_valid<=1 on the accept edge itself.
  - mul_a and mul_b are not updated; response latency is 1 cycle.
  - rr_ptr and rsp_id update normally.
- Not defined: zero operands take the normal CALC path with MUL_LAT latency.

Test Plan:
- Single request, requester 2: a=0xFF, b=0xFF, MUL_LAT=2, rsp_ready=1.
  - -> rsp_valid 2 cycles after accept; rsp_prod=0xFE01; rsp_id=2; rr_ptr=3.
- All 4 requesters valid continuously after reset, operands a=i+1, b=3.
  - -> grant order 0,1,2,3,0.
  - -> products 0x0003, 0x0006, 0x0009, 0x000C.
  - -> no grant while busy=1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid, with a=0x12, b=0x34.
  - -> rsp_prod=0x03A8 held stable; req_ready=0 throughout; accept resumes the cycle after the handshake.
- Reset asserted asynchronously mid-CALC.
  - -> all outputs 0 immediately, no response issued.
  - -> after release, a request from requester 1 is granted first (rr_ptr=0 and requester 0 idle).
- Zero operands a=0x00, b=0x7F, requester 3.
  - -> macro off: rsp_prod=0 after MUL_LAT cycles.
  - -> macro on: rsp_valid on the cycle after accept, mul_a/mul_b unchanged.
- Exhaustive 65536 operand pairs through requester 0, with a reference multiplier on mul_p.
  - -> every rsp_prod equals a*b; rsp_id=0 for every response.

Source files
------------

// File: rtl/mult_share_sched.sv
// Round-robin scheduler time-sharing one external combinational multiplier.
// Optional MULT_SHARE_ZERO_BYPASS_EN: zero operands answer at once.
module mult_share_sched #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 8,
   parameter int MUL_LAT = 2,
   parameter int IDW     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [WIDTH-1:0]      mul_a,
   output logic [WIDTH-1:0]      mul_b,
   input  logic [2*WIDTH-1:0]    mul_p,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [2*WIDTH-1:0]    rsp_prod,
   output logic                  busy
);

   localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      HOLD
   } state_e;

   state_e             state_q, state_d;
   logic [IDW-1:0]     rr_q, rr_d;
   logic [IDW-1:0]     id_q, id_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic               vld_q, vld_d;

   logic [NREQ-1:0]    gnt;
   logic               gnt_any;
   logic [IDW-1:0]     gnt_id;
   logic [IDW-1:0]     gnt_nxt;
   logic [WIDTH-1:0]   sel_a, sel_b;
   logic               zero_byp;

   // Rotating-priority search starting at rr_q; only offered while idle.
   always_comb begin : arb
      int idx;
      gnt     = '0;
      gnt_any = 1'b0;
      gnt_id  = '0;
      idx     = 0;
      if (state_q == IDLE) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (!gnt_any && req_valid[idx]) begin
               gnt_any  = 1'b1;
               gnt[idx] = 1'b1;
               gnt_id   = IDW'(idx);
            end
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_a = req_a[i*WIDTH +: WIDTH];
            sel_b = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   assign gnt_nxt = IDW'((int'(gnt_id) + 1) % NREQ);

`ifdef MULT_SHARE_ZERO_BYPASS_EN
   assign zero_byp = (sel_a == '0) || (sel_b == '0);
`else
   assign zero_byp = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      prod_d  = prod_q;
      vld_d   = vld_q;
      unique case (state_q)
         IDLE: begin
            if (gnt_any) begin
               id_d = gnt_id;
               rr_d = gnt_nxt;
               if (zero_byp) begin
                  prod_d  = '0;
                  vld_d   = 1'b1;
                  state_d = HOLD;
               end else begin
                  a_d     = sel_a;
                  b_d     = sel_b;
                  cnt_d   = CW'(MUL_LAT - 1);
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               prod_d  = mul_p;
               vld_d   = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (rsp_ready) begin
               vld_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         id_q    <= '0;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         prod_q  <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         prod_q  <= prod_d;
         vld_q   <= vld_d;
      end
   end

   assign req_ready = gnt;
   assign mul_a     = a_q;
   assign mul_b     = b_q;
   assign rsp_valid = vld_q;
   assign rsp_id    = id_q;
   assign rsp_prod  = prod_q;
   assign busy      = (state_q != IDLE);

endmodule
